// File: rtl/dt_fm.sv
// dt_fm: frame-lock detector for a 64-string x 10-word x 16-bit serial stream.
// The dCLK/dFM/dDAT inputs are resynchronised into clk, and each bit is taken on a falling dCLK edge.
module dt_fm (
    input  logic clk,
    input  logic rst,
    input  logic dCLK,
    input  logic dFM,
    input  logic dDAT,
    output logic FRM
);
    typedef enum logic [1:0] {SEARCH, CHECK, LOCK} state_t;

    localparam logic [11:0] WD_MAX    = 12'hFFF;
    localparam logic [3:0]  LAST_BIT  = 4'd15;
    localparam logic [3:0]  LAST_WORD = 4'd9;

    state_t      state, next_state;
    logic [1:0]  clk_sync, fm_sync, dat_sync;
    logic        clk_prev;
    logic        sample, fm, dat;
    logic [3:0]  bit_cnt, word_cnt;
    logic [5:0]  str_cnt;
    logic [5:0]  shift;
    logic [11:0] wd_cnt;
    logic        pos0, hdr_bad, frame_err, timeout, restart, frm_next;

    // NOTE: every clocked block uses non-blocking assignments, so each register
    // samples values from before the edge and the order of the blocks does not matter.
    always_ff @(posedge clk) begin
        if (rst) begin
            clk_sync <= '0;
            fm_sync  <= '0;
            dat_sync <= '0;
            clk_prev <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], dCLK};
            fm_sync  <= {fm_sync[0], dFM};
            dat_sync <= {dat_sync[0], dDAT};
            clk_prev <= clk_sync[1];
        end
    end

    assign sample = clk_prev & ~clk_sync[1];
    assign fm     = fm_sync[1];
    assign dat    = dat_sync[1];

    // The counters hold the frame position of the bit that is sampled next.
    assign pos0      = (bit_cnt == 4'd0) && (word_cnt == 4'd0) && (str_cnt == 6'd0);
    assign hdr_bad   = (bit_cnt == LAST_BIT) && (word_cnt == 4'd0) &&
                       ({shift, dat} != {str_cnt, ~str_cnt[0]});
    assign frame_err = hdr_bad || (fm != pos0);
    assign timeout   = (wd_cnt == WD_MAX) && !sample;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= SEARCH;
            FRM   <= 1'b0;
        end else begin
            state <= next_state;
            FRM   <= frm_next;
        end
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave a signal unassigned and infer a latch.
    always_comb begin
        next_state = state;
        restart    = 1'b0;
        if (timeout) begin
            next_state = SEARCH;
        end else if (sample) begin
            if (state == SEARCH || frame_err) begin
                // If this sample carries a frame marker, it is taken as bit 0 of a new frame.
                next_state = fm ? CHECK : SEARCH;
                restart    = fm;
            end else if (pos0) begin
                next_state = LOCK;
            end
        end
    end

    always_comb begin
        frm_next = (next_state == LOCK);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt  <= '0;
            word_cnt <= '0;
            str_cnt  <= '0;
            shift    <= '0;
            wd_cnt   <= '0;
        end else if (sample) begin
            wd_cnt <= '0;
            shift  <= {shift[4:0], dat};
            if (next_state == SEARCH) begin
                bit_cnt  <= '0;
                word_cnt <= '0;
                str_cnt  <= '0;
            end else if (restart) begin
                bit_cnt  <= 4'd1;
                word_cnt <= '0;
                str_cnt  <= '0;
            end else if (bit_cnt == LAST_BIT) begin
                bit_cnt <= '0;
                if (word_cnt == LAST_WORD) begin
                    word_cnt <= '0;
                    str_cnt  <= str_cnt + 6'd1;
                end else begin
                    word_cnt <= word_cnt + 4'd1;
                end
            end else begin
                bit_cnt <= bit_cnt + 4'd1;
            end
        end else if (wd_cnt != WD_MAX) begin
            wd_cnt <= wd_cnt + 12'd1;
        end
    end

endmodule

// File: tb/tb_dt_fm.sv
// Directed bench for dt_fm: drives a serial frame stream and checks FRM at the points where lock is gained or lost.
// Each bit takes 2 clk (dCLK is high for one clk and low for the next), so that whole frames fit in a short run.
module tb_dt_fm;
    logic clk = 1'b0;
    logic rst, dCLK, dFM, dDAT;
    logic FRM;
    int   tests = 0;
    int   fails = 0;

    dt_fm dut (
        .clk (clk),
        .rst (rst),
        .dCLK(dCLK),
        .dFM (dFM),
        .dDAT(dDAT),
        .FRM (FRM)
    );

    always #15 clk = ~clk;

    task automatic check(input string tag, input logic got, input logic exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: FRM=%b expected %b", tag, got, exp);
        end
    endtask

    // Word 0 of each string carries {9'h15A, s, ~s[0]}. If bad_str names a string, bit 0 of its header is flipped.
    function automatic logic stream_bit(input int pos, input int bad_str);
        int s, w, b;
        logic [15:0] word;
        s = pos / 160;
        w = (pos % 160) / 16;
        b = pos % 16;
        if (w == 0) begin
            word = {9'h15A, s[5:0], ~s[0]};
            if (s == bad_str) word[0] = ~word[0];
        end else begin
            word = {s[5:0], w[3:0], 6'h2B};
        end
        return word[15 - b];
    endfunction

    task automatic send_bit(input logic fm, input logic d);
        @(negedge clk);
        dCLK = 1'b1;
        dFM  = fm;
        dDAT = d;
        @(negedge clk);
        dCLK = 1'b0;
    endtask

    task automatic send_range(input int from, input int to, input logic with_fm, input int bad_str);
        for (int p = from; p <= to; p++)
            send_bit(with_fm && (p == 0), stream_bit(p, bad_str));
    endtask

    // Waits long enough for the last sent bit to reach FRM (less than 4 clk after dCLK falls), then checks FRM.
    task automatic settle_check(input string tag, input logic exp);
        repeat (3) @(posedge clk);
        #1;
        check(tag, FRM, exp);
    endtask

    // Sends a frame marker, one full valid frame and the next marker. Lock must appear only on that second marker.
    task automatic relock(input string pfx);
        send_range(0, 0, 1'b1, -1);
        settle_check({pfx, "_bit0"}, 1'b0);
        send_range(1, 10239, 1'b1, -1);
        settle_check({pfx, "_frame_end"}, 1'b0);
        send_range(0, 0, 1'b1, -1);
        settle_check({pfx, "_lock"}, 1'b1);
    endtask

    initial begin
        rst  = 1'b1;
        dCLK = 1'b0;
        dFM  = 1'b0;
        dDAT = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset", FRM, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Headers are valid but no frame marker is sent, so FRM never rises.
        send_range(0, 99, 1'b0, -1);
        settle_check("no_fm", 1'b0);

        relock("init");
        send_range(1, 19, 1'b0, -1);
        settle_check("init_run", 1'b1);

        // A one-clk reset while locked drops FRM on the next edge, and lock then needs a full new frame.
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst_pulse", FRM, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        send_range(20, 29, 1'b0, -1);
        settle_check("post_rst", 1'b0);
        relock("rst");

        // A frame marker at bit 40 of a locked frame starts a new frame at that bit.
        send_range(1, 39, 1'b0, -1);
        settle_check("pre_fm", 1'b1);
        relock("fm");

        // A dCLK stall shorter than 4096 clk keeps lock. A longer stall trips the watchdog.
        send_range(1, 19, 1'b0, -1);
        settle_check("pre_stall", 1'b1);
        repeat (4000) @(posedge clk);
        #1;
        check("stall_4000", FRM, 1'b1);
        repeat (200) @(posedge clk);
        #1;
        check("watchdog", FRM, 1'b0);
        relock("wd");

        // String 5 header 0x0B instead of 0x0A is caught on its last bit (bit 815).
        send_range(1, 814, 1'b0, 5);
        settle_check("pre_hdr", 1'b1);
        send_range(815, 815, 1'b0, 5);
        settle_check("hdr_err", 1'b0);
        send_range(816, 1000, 1'b0, 5);
        settle_check("hdr_stay", 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
